// File: rtl/seq_or_pkg.sv
// Shared types and defaults for the seq_or two-thread stimulus generator.
// Thread-state and thread-select encodings live here.
package seq_or_pkg;

    localparam int DW_DEF  = 32;
    localparam int V_A_DEF = 1;
    localparam int V_C_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_GAP    = 3'd2,
        ST_DATA   = 3'd3,
        ST_END    = 3'd4
    } thr_state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_A    = 2'b01,
        SEL_C    = 2'b10,
        SEL_BOTH = 2'b11
    } sel_t;

endpackage

// File: rtl/seq_or_thread.sv
// One stimulus thread: launch strobe, optional idle gap, data beat, then e beat.
// GAP=0 gives thread A timing, GAP=1 gives thread C timing.
module seq_or_thread
    import seq_or_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter bit GAP = 1'b0,
    parameter int VAL = V_A_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          err,
    output logic          launch,
    output logic          dv,
    output logic [DW-1:0] data,
    output logic          ev,
    output logic [DW-1:0] e,
    output logic          act,
    output logic          live_nxt,
    output logic          end_nxt
);

    localparam logic [DW-1:0] VAL_W = DW'(VAL);
    localparam logic [DW-1:0] VAL_E = DW'(VAL + 1);

    thr_state_t state;
    thr_state_t state_nxt;
    logic       err_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (go) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = GAP ? ST_GAP : ST_DATA;
            ST_GAP:    state_nxt = ST_DATA;
            ST_DATA:   state_nxt = ST_END;
            ST_END:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign act      = (state != ST_IDLE);
    assign end_nxt  = (state_nxt == ST_END);
    assign live_nxt = (state_nxt == ST_LAUNCH) || (state_nxt == ST_GAP)
                   || (state_nxt == ST_DATA);

    // Outputs are registered off the next state so they change only on edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            err_q  <= 1'b0;
            launch <= 1'b0;
            dv     <= 1'b0;
            data   <= '0;
            ev     <= 1'b0;
            e      <= '0;
        end else begin
            state  <= state_nxt;
            if (go && state == ST_IDLE) err_q <= err;
            launch <= (state_nxt == ST_LAUNCH);
            dv     <= (state_nxt == ST_DATA);
            data   <= (state_nxt == ST_DATA) ? VAL_W : '0;
            ev     <= (state_nxt == ST_END);
            e      <= (state_nxt == ST_END) ? (err_q ? VAL_E : VAL_W) : '0;
        end
    end

endmodule

// File: rtl/seq_or_gen.sv
// Two-thread "or" stimulus generator with a one-cycle start/ready launch.
// Optional SEQ_OR_GEN_ERR_EN adds err_inj to corrupt every e of a transaction.
module seq_or_gen
    import seq_or_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int V_A = V_A_DEF,
    parameter int V_C = V_C_DEF,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    sel,
`ifdef SEQ_OR_GEN_ERR_EN
    input  logic          err_inj,
`endif
    output logic          ready,
    output logic          busy,
    output logic          a,
    output logic          c,
    output logic [DW-1:0] b,
    output logic [DW-1:0] d,
    output logic [DW-1:0] e,
    output logic          done,
    output logic [CW-1:0] txn_cnt
);

    logic err;
`ifdef SEQ_OR_GEN_ERR_EN
    assign err = err_inj;
`else
    assign err = 1'b0;
`endif

    logic want_a, want_c, go;
    logic a_dv, a_ev, a_act, a_live, a_end;
    logic c_dv, c_ev, c_act, c_live, c_end;
    logic [DW-1:0] a_data, a_e, c_data, c_e;
    logic done_nxt;

    always_comb begin
        want_a = 1'b0;
        want_c = 1'b0;
        unique case (sel_t'(sel))
            SEL_A:    want_a = 1'b1;
            SEL_C:    want_c = 1'b1;
            SEL_BOTH: begin
                want_a = 1'b1;
                want_c = 1'b1;
            end
            default:  ;
        endcase
    end

    assign busy  = a_act | c_act;
    assign ready = ~busy;
    assign go    = start & ready;

    seq_or_thread #(.DW(DW), .GAP(1'b0), .VAL(V_A)) u_thr_a (
        .clk(clk), .rst(rst), .go(go & want_a), .err(err),
        .launch(a), .dv(a_dv), .data(a_data), .ev(a_ev), .e(a_e),
        .act(a_act), .live_nxt(a_live), .end_nxt(a_end)
    );

    seq_or_thread #(.DW(DW), .GAP(1'b1), .VAL(V_C)) u_thr_c (
        .clk(clk), .rst(rst), .go(go & want_c), .err(err),
        .launch(c), .dv(c_dv), .data(c_data), .ev(c_ev), .e(c_e),
        .act(c_act), .live_nxt(c_live), .end_nxt(c_end)
    );

    assign b = a_dv ? a_data : '0;
    assign d = c_dv ? c_data : '0;
    assign e = a_ev ? a_e : (c_ev ? c_e : '0);

    // A transaction finishes when a thread ends and no thread keeps running.
    assign done_nxt = (a_end | c_end) & ~a_live & ~c_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            txn_cnt <= '0;
        end else begin
            done <= done_nxt;
            if (done_nxt) txn_cnt <= txn_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_seq_or_gen.sv
// Bench for seq_or_gen: directed vector table plus random traffic
// checked against an event-schedule model of the two threads.
module tb_seq_or_gen;

    localparam int DW = 32;
    localparam int VA = 1;
    localparam int VC = 2;
    localparam int CW = 2;
    localparam int NC = 1024;
`ifdef SEQ_OR_GEN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1:0]    sel;
    bit            err_cur;
    logic          ready, busy, a, c, done;
    logic [DW-1:0] b, d, e;
    logic [CW-1:0] txn_cnt;
`ifdef SEQ_OR_GEN_ERR_EN
    logic          err_inj;
    assign err_inj = err_cur;
`endif

    seq_or_gen #(.DW(DW), .V_A(VA), .V_C(VC), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
`ifdef SEQ_OR_GEN_ERR_EN
        .err_inj(err_inj),
`endif
        .ready(ready), .busy(busy), .a(a), .c(c),
        .b(b), .d(d), .e(e), .done(done), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit s; bit [1:0] sl;
        bit a; bit c; int b; int d; int e;
        bit done; bit busy; int cnt;
    } vec_t;

    // expected outputs per cycle index (cycle t follows edge t-1)
    bit m_a[NC], m_c[NC], m_done[NC], m_rst[NC];
    int m_b[NC], m_d[NC], m_e[NC];
    int last_busy = 0;
    int mcnt = 0;
    int ecnt = 0;
    int vectors = 0;
    int miscompares = 0;

    function automatic vec_t mk(bit r, bit s, bit [1:0] sl, bit xa, bit xc,
                                int xb, int xd, int xe, bit xdn, bit xbs, int xcnt);
        vec_t v;
        v.r = r; v.s = s; v.sl = sl;
        v.a = xa; v.c = xc; v.b = xb; v.d = xd; v.e = xe;
        v.done = xdn; v.busy = xbs; v.cnt = xcnt;
        return v;
    endfunction

    task automatic model_edge(input int n, input bit r, input bit s,
                              input bit [1:0] sl, input bit er);
        int eo;
        if (r) begin
            for (int t = n + 1; t <= n + 4; t++) begin
                m_a[t] = 0; m_c[t] = 0; m_done[t] = 0;
                m_b[t] = 0; m_d[t] = 0; m_e[t] = 0;
            end
            m_rst[n+1] = 1;
            last_busy = n;
        end else if (s && sl != 2'b00 && n > last_busy) begin
            eo = (ERR_EN && er) ? 1 : 0;
            if (sl[0]) begin
                m_a[n+1] = 1; m_b[n+2] = VA; m_e[n+3] = VA + eo;
                last_busy = n + 3;
            end
            if (sl[1]) begin
                m_c[n+1] = 1; m_d[n+3] = VC; m_e[n+4] = VC + eo;
                last_busy = n + 4;
            end
            m_done[last_busy] = 1;
        end
    endtask

    task automatic model_obs(input int t);
        if (m_rst[t]) mcnt = 0;
        if (m_done[t]) mcnt = (mcnt + 1) % (1 << CW);
    endtask

    task automatic tick(input bit r, input bit s, input bit [1:0] sl, input bit er);
        int n;
        n = ecnt + 1;
        rst = r; start = s; sel = sl; err_cur = er;
        model_edge(n, r, s, sl, er);
        @(posedge clk);
        #1;
        ecnt = n;
        model_obs(n + 1);
    endtask

    task automatic check(input string nm, input bit xa, input bit xc, input int xb,
                         input int xd, input int xe, input bit xdn, input bit xbs,
                         input int xcnt);
        vectors++;
        if (a !== xa || c !== xc || b !== 32'(xb) || d !== 32'(xd)
            || e !== 32'(xe) || done !== xdn || busy !== xbs
            || ready !== !xbs || txn_cnt !== CW'(xcnt)) begin
            miscompares++;
            $display("FAIL %s edge %0d got a=%b c=%b b=%0d d=%0d e=%0d done=%b busy=%b ready=%b cnt=%0d exp a=%b c=%b b=%0d d=%0d e=%0d done=%b busy=%b cnt=%0d",
                     nm, ecnt, a, c, b, d, e, done, busy, ready, txn_cnt,
                     xa, xc, xb, xd, xe, xdn, xbs, xcnt);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // reset, thread A
        tbl.push_back(mk(1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1, 1,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,1,1,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,1));
        // thread C
        tbl.push_back(mk(0,1,2, 0,1,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,2,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,2,1,1,2));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,2));
        // both threads
        tbl.push_back(mk(0,1,3, 1,1,0,0,0,0,1,2));
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,0,1,2));
        tbl.push_back(mk(0,0,0, 0,0,0,2,1,0,1,2));
        tbl.push_back(mk(0,0,0, 0,0,0,0,2,1,1,3));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,3));
        // sel=00 ignored, start while busy ignored, count wraps 3->0
        tbl.push_back(mk(0,1,0, 0,0,0,0,0,0,0,3));
        tbl.push_back(mk(0,1,1, 1,0,0,0,0,0,1,3));
        tbl.push_back(mk(0,1,2, 0,0,1,0,0,0,1,3));
        tbl.push_back(mk(0,1,3, 0,0,0,0,1,1,1,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,0));
        // reset mid-transaction
        tbl.push_back(mk(0,1,2, 0,1,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,0));
        // start held: back-to-back A every 4 cycles
        tbl.push_back(mk(0,1,1, 1,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1, 0,0,1,0,0,0,1,0));
        tbl.push_back(mk(0,1,1, 0,0,0,0,1,1,1,1));
        tbl.push_back(mk(0,1,1, 0,0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,1, 1,0,0,0,0,0,1,1));
        tbl.push_back(mk(0,1,1, 0,0,1,0,0,0,1,1));
        tbl.push_back(mk(0,1,1, 0,0,0,0,1,1,1,2));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,0,2));

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r, tbl[i].s, tbl[i].sl, 1'b0);
            check("table", tbl[i].a, tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].e,
                  tbl[i].done, tbl[i].busy, tbl[i].cnt);
        end

        for (int i = 0; i < 600; i++) begin
            int t;
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            t = ecnt + 1;
            check("random", m_a[t], m_c[t], m_b[t], m_d[t], m_e[t],
                  m_done[t], t <= last_busy, mcnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
